// File: rtl/microprocessor_pkg.sv
// Shared definitions for the minimal single-cycle processor: opcodes,
// instruction field positions, field helpers and the default ROM image.
package microprocessor_pkg;

    localparam int INSTR_W       = 16;
    localparam int DEFAULT_DEPTH = 256;

    localparam int OP_LSB    = 12;
    localparam int OP_W      = 4;
    localparam int RD_LSB    = 9;
    localparam int RS_LSB    = 6;
    localparam int RT_LSB    = 3;
    localparam int REG_IDX_W = 3;
    localparam int IMM_W     = 9;
    localparam int ADDR_W    = 8;
    localparam int NUM_REGS  = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_OUT  = 4'd7,
        OP_JMP  = 4'd8,
        OP_BEQZ = 4'd9,
        OP_HALT = 4'd15
    } opcode_e;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [DEFAULT_DEPTH-1:0][INSTR_W-1:0] program_t;

    // Entry 0 is the rightmost word; everything past HALT is NOP.
    localparam program_t DEFAULT_PROGRAM = {
        {(DEFAULT_DEPTH-7){16'h0000}},
        16'hF000,   // 6 HALT
        16'h7100,   // 5 OUT r4
        16'h3850,   // 4 SUB r4,r1,r2
        16'h70C0,   // 3 OUT r3
        16'h2650,   // 2 ADD r3,r1,r2
        16'h1407,   // 1 LDI r2,7
        16'h1205    // 0 LDI r1,5
    };

    function automatic opcode_e instr_op(input instr_t i);
        return opcode_e'(i[OP_LSB +: OP_W]);
    endfunction

    function automatic logic [REG_IDX_W-1:0] instr_rd(input instr_t i);
        return i[RD_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] instr_rs(input instr_t i);
        return i[RS_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] instr_rt(input instr_t i);
        return i[RT_LSB +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/microprocessor_alu.sv
// Combinational ALU: arithmetic and bitwise ops, with carry/borrow reporting
// and a write-enable telling the core whether the carry flag should change.
module microprocessor_alu
    import microprocessor_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  opcode_e              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 carry_out,
    output logic                 carry_we
);

    logic [WORD_SIZE:0] sum;
    logic [WORD_SIZE:0] diff;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        // The extra top bit of an unsigned subtraction is set exactly when a < b.
        diff      = {1'b0, a} - {1'b0, b};
        result    = '0;
        carry_out = 1'b0;
        carry_we  = 1'b0;
        case (op)
            OP_ADD: begin
                result    = sum[WORD_SIZE-1:0];
                carry_out = sum[WORD_SIZE];
                carry_we  = 1'b1;
            end
            OP_SUB: begin
                result    = diff[WORD_SIZE-1:0];
                carry_out = diff[WORD_SIZE];
                carry_we  = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/microprocessor.sv
// Single-cycle, non-pipelined processor: internal ROM, 8-entry register file,
// carry flag, and a registered output port written only by OUT.
module microprocessor
    import microprocessor_pkg::*;
#(
    parameter int word_size  = 32,
    parameter int PROG_DEPTH = DEFAULT_DEPTH,
    parameter logic [PROG_DEPTH-1:0][INSTR_W-1:0] PROGRAM = DEFAULT_PROGRAM
) (
    input  logic               clk,
    input  logic               rst,
    output logic [word_size:0] output_data
);

    localparam int PC_W = $clog2(PROG_DEPTH);

    logic [PC_W-1:0]      pc_q, pc_d, pc_inc, jump_target;
    logic [word_size-1:0] regs_q [NUM_REGS];
    logic [word_size-1:0] regs_d [NUM_REGS];
    logic                 carry_q, carry_d;
    logic                 halted_q, halted_d;
    logic [word_size:0]   output_data_q, output_data_d;

    instr_t               instr;
    opcode_e              op;
    logic [REG_IDX_W-1:0] rd, rs, rt;
    logic [word_size-1:0] rd_val, rs_val, rt_val, imm_ext;
    logic [word_size-1:0] alu_result;
    logic                 alu_carry, alu_carry_we;

    assign instr = PROGRAM[pc_q];
    assign op    = instr_op(instr);
    assign rd    = instr_rd(instr);
    assign rs    = instr_rs(instr);
    assign rt    = instr_rt(instr);

    // r0 is hard-wired to zero on every read port, including the BEQZ test.
    assign rd_val      = (rd == '0) ? '0 : regs_q[rd];
    assign rs_val      = (rs == '0) ? '0 : regs_q[rs];
    assign rt_val      = (rt == '0) ? '0 : regs_q[rt];
    assign imm_ext     = word_size'(instr[IMM_W-1:0]);
    assign jump_target = PC_W'(instr[ADDR_W-1:0]);
    assign pc_inc      = (pc_q == PC_W'(PROG_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);

    microprocessor_alu #(
        .WORD_SIZE (word_size)
    ) u_alu (
        .op        (op),
        .a         (rs_val),
        .b         (rt_val),
        .result    (alu_result),
        .carry_out (alu_carry),
        .carry_we  (alu_carry_we)
    );

    always_comb begin
        pc_d          = pc_inc;
        regs_d        = regs_q;
        carry_d       = carry_q;
        halted_d      = halted_q;
        output_data_d = output_data_q;
        if (halted_q) begin
            pc_d = pc_q;
        end else begin
            case (op)
                OP_LDI: regs_d[rd] = imm_ext;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    regs_d[rd] = alu_result;
                    if (alu_carry_we) carry_d = alu_carry;
                end
                OP_OUT:  output_data_d = {carry_q, rs_val};
                OP_JMP:  pc_d = jump_target;
                OP_BEQZ: if (rd_val == '0) pc_d = jump_target;
                OP_HALT: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
                default: ;
            endcase
        end
        // Writes aimed at r0 are dropped here, after the carry has been taken.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            carry_q       <= 1'b0;
            halted_q      <= 1'b0;
            output_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q          <= pc_d;
            carry_q       <= carry_d;
            halted_q      <= halted_d;
            output_data_q <= output_data_d;
            regs_q        <= regs_d;
        end
    end

    assign output_data = output_data_q;

endmodule

// File: tb/tb_microprocessor.sv
// Bench for microprocessor: three instances (default ROM, hand-written ROM,
// pseudo-random ROM) compared every cycle against an instruction-level model.
module tb_microprocessor;

    typedef logic [255:0][15:0] prog_t;

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h1, rd, imm};
    endfunction

    function automatic logic [15:0] enc_br(input logic [3:0] op, input logic [2:0] rs,
                                           input logic [7:0] addr);
        return {op, rs, 1'b0, addr};
    endfunction

    function automatic prog_t build_default();
        prog_t p;
        p    = '0;
        p[0] = enc_ldi(3'd1, 9'd5);
        p[1] = enc_ldi(3'd2, 9'd7);
        p[2] = enc_r(4'd2, 3'd3, 3'd1, 3'd2);
        p[3] = enc_r(4'd7, 3'd0, 3'd3, 3'd0);
        p[4] = enc_r(4'd3, 3'd4, 3'd1, 3'd2);
        p[5] = enc_r(4'd7, 3'd0, 3'd4, 3'd0);
        p[6] = 16'hF000;
        return p;
    endfunction

    function automatic prog_t build_patch();
        prog_t p;
        p     = '0;
        p[0]  = enc_ldi(3'd1, 9'd1);
        p[1]  = enc_r(4'd3, 3'd2, 3'd0, 3'd1);
        p[2]  = enc_r(4'd2, 3'd3, 3'd2, 3'd1);
        p[3]  = enc_r(4'd7, 3'd0, 3'd3, 3'd0);
        p[4]  = enc_r(4'd6, 3'd3, 3'd3, 3'd3);
        p[5]  = enc_r(4'd7, 3'd0, 3'd3, 3'd0);
        p[6]  = enc_ldi(3'd5, 9'd3);
        p[7]  = enc_r(4'd2, 3'd0, 3'd5, 3'd5);
        p[8]  = enc_r(4'd7, 3'd0, 3'd0, 3'd0);
        p[9]  = enc_r(4'd4, 3'd6, 3'd1, 3'd5);
        p[10] = enc_r(4'd7, 3'd0, 3'd6, 3'd0);
        p[11] = enc_br(4'd9, 3'd0, 8'd13);
        p[12] = enc_r(4'd7, 3'd0, 3'd5, 3'd0);
        p[13] = enc_br(4'd8, 3'd0, 8'd15);
        p[14] = enc_r(4'd7, 3'd0, 3'd5, 3'd0);
        p[15] = 16'hF000;
        return p;
    endfunction

    // xorshift32 image; HALT is made rare so programs run for a while.
    function automatic prog_t build_rand(input logic [31:0] seed);
        prog_t       p;
        logic [31:0] s;
        logic [3:0]  op;
        p = '0;
        s = seed;
        for (int i = 0; i < 256; i++) begin
            s  = s ^ (s << 13);
            s  = s ^ (s >> 17);
            s  = s ^ (s << 5);
            op = s[3:0];
            if (op == 4'hF && s[4]) op = 4'h7;
            p[i] = {op, s[27:16]};
        end
        return p;
    endfunction

    localparam prog_t PROG_DEF   = build_default();
    localparam prog_t PROG_PATCH = build_patch();
    localparam prog_t PROG_RAND  = build_rand(32'h1234_5678);

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] out_def, out_patch, out_rand;

    always #5 clk = ~clk;

    microprocessor u_def (
        .clk         (clk),
        .rst         (rst),
        .output_data (out_def)
    );

    microprocessor #(.PROGRAM(PROG_PATCH)) u_patch (
        .clk         (clk),
        .rst         (rst),
        .output_data (out_patch)
    );

    microprocessor #(.PROGRAM(PROG_RAND)) u_rand (
        .clk         (clk),
        .rst         (rst),
        .output_data (out_rand)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_pc    [3];
    logic [31:0] m_reg   [3][8];
    logic        m_carry [3];
    logic        m_halt  [3];
    logic [32:0] m_out   [3];
    bit          m_valid = 1'b0;

    function automatic logic [15:0] fetch(input int k, input int pc);
        case (k)
            0:       return PROG_DEF[pc];
            1:       return PROG_PATCH[pc];
            default: return PROG_RAND[pc];
        endcase
    endfunction

    task automatic model_step(input int k, input logic r);
        logic [15:0] ins;
        logic [3:0]  op;
        int          rd, rs, rt, nxt;
        logic [31:0] a, b, res;
        bit          wr;
        if (r) begin
            m_pc[k]    = 0;
            m_carry[k] = 1'b0;
            m_halt[k]  = 1'b0;
            m_out[k]   = '0;
            for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
            return;
        end
        if (m_halt[k]) return;
        ins = fetch(k, m_pc[k]);
        op  = ins[15:12];
        rd  = int'(ins[11:9]);
        rs  = int'(ins[8:6]);
        rt  = int'(ins[5:3]);
        a   = m_reg[k][rs];
        b   = m_reg[k][rt];
        res = '0;
        wr  = 1'b0;
        nxt = (m_pc[k] + 1) % 256;
        case (op)
            4'd1: begin res = 32'(ins[8:0]); wr = 1'b1; end
            4'd2: begin
                res        = a + b;
                m_carry[k] = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
                wr         = 1'b1;
            end
            4'd3: begin
                res        = a - b;
                m_carry[k] = (a < b);
                wr         = 1'b1;
            end
            4'd4: begin res = a & b; wr = 1'b1; end
            4'd5: begin res = a | b; wr = 1'b1; end
            4'd6: begin res = a ^ b; wr = 1'b1; end
            4'd7: m_out[k] = {m_carry[k], a};
            4'd8: nxt = int'(ins[7:0]);
            4'd9: if (m_reg[k][rd] == 32'd0) nxt = int'(ins[7:0]);
            4'd15: begin m_halt[k] = 1'b1; nxt = m_pc[k]; end
            default: ;
        endcase
        if (wr && rd != 0) m_reg[k][rd] = res;
        m_pc[k] = nxt;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r);
        logic [32:0] obs [3];
        logic [32:0] e;
        rst = r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_step(k, r);
        if (r) m_valid = 1'b1;
        if (m_valid) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(m_out[k]);
            obs[0] = out_def;
            obs[1] = out_patch;
            obs[2] = out_rand;
            for (int k = 0; k < 3; k++) begin
                e = exp_q.pop_front();
                check_val($sformatf("model_out%0d", k), 64'(obs[k]), 64'(e));
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        cycle(1'b1);
        cycle(1'b1);
        check_val("reset_out", 64'(out_def), 64'h0);
        check_val("reset_pc", 64'(u_def.pc_q), 64'd0);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            check_val("pre_out_hold", 64'(out_def), 64'h0);
        end
        cycle(1'b0);
        check_val("add_out", 64'(out_def), 64'h0_0000000C);
        cycle(1'b0);
        check_val("add_out_hold", 64'(out_def), 64'h0_0000000C);
        cycle(1'b0);
        check_val("sub_borrow_out", 64'(out_def), 64'h1_FFFFFFFE);
        cycle(1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0);
        check_val("halt_out", 64'(out_def), 64'h1_FFFFFFFE);
        check_val("halt_pc", 64'(u_def.pc_q), 64'd6);

        // Reset while halted; the hand-written program restarts alongside.
        cycle(1'b1);
        check_val("halt_reset_out", 64'(out_def), 64'h0);
        check_val("halt_reset_pc", 64'(u_def.pc_q), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        check_val("rerun_add_out", 64'(out_def), 64'h0_0000000C);
        check_val("wrap_carry_out", 64'(out_patch), 64'h1_00000000);
        cycle(1'b0);
        cycle(1'b0);
        check_val("rerun_sub_out", 64'(out_def), 64'h1_FFFFFFFE);
        check_val("xor_keeps_carry", 64'(out_patch), 64'h1_00000000);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        check_val("r0_add_carry", 64'(out_patch), 64'h0_00000000);
        cycle(1'b0);
        cycle(1'b0);
        check_val("and_out", 64'(out_patch), 64'h0_00000001);
        for (int i = 0; i < 12; i++) cycle(1'b0);
        check_val("branch_skip_out", 64'(out_patch), 64'h0_00000001);
        check_val("branch_halt_pc", 64'(u_patch.pc_q), 64'd15);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
